// File: rtl/logic_op_pkg.sv
// ============================================================================
// Package : logic_op_pkg
// Brief   : Sel encoding, state type and helpers for logic_op_identifier.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEARCH   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_CONFLICT = 2'd3
    } state_e;

    function automatic logic op_eval(input logic [1:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        return r;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Only meaningful for a one-hot mask; anything else maps to 00.
    function automatic logic [1:0] onehot_to_sel(input logic [3:0] m);
        logic [1:0] s;
        case (m)
            4'b0010: s = 2'b01;
            4'b0100: s = 2'b10;
            4'b1000: s = 2'b11;
            default: s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_match.sv
// ============================================================================
// Module : logic_op_match
// Brief  : Combinational per-sample consistency vector for the four ops.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_op_match
    import logic_op_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       y,
    output logic [3:0] match
);

    for (genvar i = 0; i < 4; i++) begin : g_op
        assign match[i] = (op_eval(2'(i), a, b) == y);
    end

endmodule

`default_nettype wire

// File: rtl/logic_op_identifier.sv
// ============================================================================
// Module : logic_op_identifier
// Brief  : Narrows the unknown 2-bit-selected logic op from observed samples.
//          Optional idle timeout in SEARCH enabled by LOGIC_OP_ID_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_op_identifier
    import logic_op_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       a,
    input  logic       b,
    input  logic       y,
    input  logic       clear,
    output logic [3:0] cand_mask,
    output logic [1:0] sel_out,
    output logic       locked,
    output logic       conflict,
    output logic [7:0] sample_cnt
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_chk
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] w_match;
    logic [3:0] w_mask_new;
    logic [2:0] w_pop;

    logic_op_match u_match (
        .a     (a),
        .b     (b),
        .y     (y),
        .match (w_match)
    );

    assign w_mask_new = mask_q & w_match;
    assign w_pop      = popcount4(w_mask_new);

`ifdef LOGIC_OP_ID_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
`ifdef LOGIC_OP_ID_TIMEOUT_EN
        idle_d  = 8'd0;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            mask_d  = MASK_ALL;
            sel_d   = 2'b00;
            cnt_d   = 8'd0;
        end else if (in_valid) begin
            // CONFLICT needs no special case: an empty mask stays empty.
            mask_d = w_mask_new;
            cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (w_pop == 3'd0) begin
                state_d = ST_CONFLICT;
                sel_d   = 2'b00;
            end else if (w_pop == 3'd1) begin
                state_d = ST_LOCKED;
                sel_d   = onehot_to_sel(w_mask_new);
            end else begin
                state_d = ST_SEARCH;
                sel_d   = 2'b00;
            end
        end
`ifdef LOGIC_OP_ID_TIMEOUT_EN
        else if (state_q == ST_SEARCH) begin
            if (idle_q == 8'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                mask_d  = MASK_ALL;
                sel_d   = 2'b00;
                cnt_d   = 8'd0;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= MASK_ALL;
            sel_q   <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LOGIC_OP_ID_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= 8'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign cand_mask  = mask_q;
    assign sel_out    = sel_q;
    assign locked     = (state_q == ST_LOCKED);
    assign conflict   = (state_q == ST_CONFLICT);
    assign sample_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_identifier.sv
// ============================================================================
// Module : tb_logic_op_identifier
// Brief  : Self-checking bench for logic_op_identifier against a candidate-set
//          reference model. Timeout scenario built with LOGIC_OP_ID_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_op_identifier;

`ifdef LOGIC_OP_ID_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       y = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] cand_mask;
    logic [1:0] sel_out;
    logic       locked;
    logic       conflict;
    logic [7:0] sample_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: surviving candidate set and accepted-sample count.
    bit [3:0] m_mask = 4'hF;
    int       m_cnt  = 0;

    always #5 clk = ~clk;

    logic_op_identifier #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .y          (y),
        .clear      (clear),
        .cand_mask  (cand_mask),
        .sel_out    (sel_out),
        .locked     (locked),
        .conflict   (conflict),
        .sample_cnt (sample_cnt)
    );

    wire [15:0] obs = {cand_mask, sel_out, locked, conflict, sample_cnt};

    function automatic bit op_ref(int s, bit pa, bit pb);
        case (s)
            0: return pa & pb;
            1: return pa | pb;
            2: return pa ^ pb;
            default: return !(pa ^ pb);
        endcase
    endfunction

    function automatic bit [15:0] exp_vec();
        int  ones = $countones(m_mask);
        bit [1:0] s = 2'b00;
        if (ones == 1)
            for (int i = 0; i < 4; i++) if (m_mask[i]) s = 2'(i);
        return {m_mask, s, bit'(ones == 1), bit'(ones == 0), 8'(m_cnt)};
    endfunction

    function automatic void model_sample(bit pa, bit pb, bit py);
        for (int s = 0; s < 4; s++) if (op_ref(s, pa, pb) != py) m_mask[s] = 1'b0;
        if (m_cnt < 255) m_cnt++;
    endfunction

    function automatic void model_clear();
        m_mask = 4'hF;
        m_cnt  = 0;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit v, input bit pa, input bit pb, input bit py, input bit clr);
        in_valid = v; a = pa; b = pb; y = py; clear = clr;
        @(posedge clk);
        if (clr) model_clear();
        else if (v) model_sample(pa, pb, py);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs !== 16'hF000) begin
            $display("FAIL reset_state: got %h expected %h", obs, 16'hF000);
            n_fail++;
        end
    endtask

    task automatic test_lock_xor();
        do_reset();
        step(1, 0, 1, 1, 0);
        n_vec++;
        if (obs !== exp_vec() || cand_mask !== 4'b0110) begin
            $display("FAIL xor_first_sample: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
        step(1, 1, 1, 0, 0);
        n_vec++;
        if (obs !== exp_vec() || obs !== {4'b0100, 2'b10, 1'b1, 1'b0, 8'd2}) begin
            $display("FAIL xor_locked: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
    endtask

    task automatic test_lock_then_conflict();
        do_reset();
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        n_vec++;
        if (obs !== exp_vec() || obs !== {4'b1000, 2'b11, 1'b1, 1'b0, 8'd2}) begin
            $display("FAIL xnor_locked: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
        step(1, 1, 1, 0, 0);
        n_vec++;
        if (obs !== exp_vec() || obs !== {4'b0000, 2'b00, 1'b0, 1'b1, 8'd3}) begin
            $display("FAIL conflict_entry: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
        step(1, 1, 0, 1, 0);
        n_vec++;
        if (obs !== exp_vec() || conflict !== 1'b1) begin
            $display("FAIL conflict_sticky: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        n_vec++;
        if (obs !== 16'hF000) begin
            $display("FAIL clear_wins: got %h expected %h", obs, 16'hF000);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 1, 1, 1, 0);
        n_vec++;
        if (obs !== exp_vec() || sample_cnt !== 8'd255 || cand_mask !== 4'b1011) begin
            $display("FAIL saturation: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
        step(1, 0, 0, 0, 0);
        n_vec++;
        if (obs !== exp_vec()) begin
            $display("FAIL eval_after_saturation: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
    endtask

    task automatic test_back_to_back_random();
        bit v, c;
        do_reset();
        for (int i = 0; i < 400; i++) begin
`ifdef LOGIC_OP_ID_TIMEOUT_EN
            v = 1'b1;
`else
            v = ($urandom_range(0, 3) != 0);
`endif
            c = ($urandom_range(0, 11) == 0);
            step(v, 1'($urandom), 1'($urandom), 1'($urandom), c);
            n_vec++;
            if (obs !== exp_vec() || (locked && conflict)) begin
                $display("FAIL random_seq[%0d]: got %h expected %h", i, obs, exp_vec());
                n_fail++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== 16'hF000) begin
            $display("FAIL async_reset: got %h expected %h", obs, 16'hF000);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step(1, 0, 1, 1, 0);
        n_vec++;
        if (obs !== exp_vec()) begin
            $display("FAIL restart_after_reset: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
    endtask

`ifdef LOGIC_OP_ID_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
        n_vec++;
        if (obs !== {4'b0111, 2'b00, 1'b0, 1'b0, 8'd1}) begin
            $display("FAIL timeout_not_yet: got %h expected %h", obs, {4'b0111, 4'b0000, 8'd1});
            n_fail++;
        end
        step(0, 0, 0, 0, 0);
        model_clear();
        n_vec++;
        if (obs !== 16'hF000) begin
            $display("FAIL timeout_expired: got %h expected %h", obs, 16'hF000);
            n_fail++;
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0);
        n_vec++;
        if (obs !== exp_vec() || cand_mask !== 4'b0111) begin
            $display("FAIL search_persists: got %h expected %h", obs, exp_vec());
            n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_xor();
        test_lock_then_conflict();
        test_clear_priority();
        test_saturation();
        test_back_to_back_random();
        test_async_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
